// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: S1 latches the request fields, S2 holds the encoded word
// (or a rejection) until the consumer takes it, with good/error delivery counters.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [2:0] FmtI  = 3'd0;
    localparam logic [2:0] FmtS  = 3'd1;
    localparam logic [2:0] FmtSb = 3'd2;
    localparam logic [2:0] FmtU  = 3'd3;
    localparam logic [2:0] FmtUj = 3'd4;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    logic        s1_valid_q, s1_valid_d;
    req_t        s1_req_q, s1_req_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q, s2_err_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        s2_adv;
    logic        s1_move;
    logic        accept;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic [31:0] s1_imm;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign s1_imm   = s1_req_q.imm;

    // Range checks: the immediate must be representable in the format's field width.
    always_comb begin
        enc_instr = 32'h0;
        enc_err   = 1'b0;
        case (s1_req_q.fmt)
            FmtI: begin
                enc_err   = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
                enc_instr = {s1_imm[11:0], s1_req_q.rs1, s1_req_q.funct3, s1_req_q.rd,
                             s1_req_q.opcode};
            end
            FmtS: begin
                enc_err   = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
                enc_instr = {s1_imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                             s1_imm[4:0], s1_req_q.opcode};
            end
            FmtSb: begin
                enc_err   = !(&s1_imm[31:12] || ~|s1_imm[31:12]) || s1_imm[0];
                enc_instr = {s1_imm[12], s1_imm[10:5], s1_req_q.rs2, s1_req_q.rs1,
                             s1_req_q.funct3, s1_imm[4:1], s1_imm[11], s1_req_q.opcode};
            end
            FmtU: begin
                enc_err   = |s1_imm[11:0];
                enc_instr = {s1_imm[31:12], s1_req_q.rd, s1_req_q.opcode};
            end
            FmtUj: begin
                enc_err   = !(&s1_imm[31:20] || ~|s1_imm[31:20]) || s1_imm[0];
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_req_q.rd,
                             s1_req_q.opcode};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_instr = 32'h0;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_req_d    = s1_req_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_req_d   = '{fmt: fmt, opcode: opcode, funct3: funct3, rd: rd, rs1: rs1, rs2: rs2,
                           imm: imm};
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = enc_instr;
                s2_err_d   = enc_err;
            end
        end

        if (s2_valid_q && out_ready) begin
            if (s2_err_q) begin
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else begin
                enc_count_d = enc_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_req_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 32'h0;
            s2_err_q    <= 1'b0;
            enc_count_q <= 16'h0;
            err_count_q <= 8'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk input 1 (single clock, all state on rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: in_valid input 1 (request present); in_ready output 1 (request accepted when in_valid&in_ready).
REQ-003 SHALL have request fields: fmt input 3 (0=I, 1=S, 2=SB, 3=U, 4=UJ, 5-7 illegal); opcode input 7; funct3 input 3; rd, rs1, rs2 input 5 each; imm input 32 (byte offset / value, sign-extended form).
REQ-004 SHALL have ports: out_valid output 1; out_ready input 1; out_instr output 32 (encoded word); out_err output 1 (request rejected).
REQ-005 SHALL have ports: enc_count output 16 (good encodings delivered); err_count output 8 (rejections delivered, saturating).

Function
REQ-006 SHALL be a two-stage pipeline: S1 captures the request and range-checks; S2 holds the encoded result driving out_*.
REQ-007 SHALL advance S2 when !S2.valid or out_ready; S1 moves into S2 on the same cycle S2 advances.
REQ-008 SHALL drive in_ready = !S1.valid or (S1 moves this cycle); in_ready SHALL NOT depend on in_valid.
REQ-009 SHALL give 2-cycle latency: request accepted at edge N appears on out_valid after edge N+1 with no backpressure; full throughput of 1 per cycle.
REQ-010 SHALL hold out_instr/out_err stable while out_valid=1 and out_ready=0.
REQ-011 SHALL encode I as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-012 SHALL encode S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-013 SHALL encode SB as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-014 SHALL encode U as {imm[31:12], rd, opcode}.
REQ-015 SHALL encode UJ as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-016 SHALL reject (out_err=1) when: I/S and imm[31:11] not all equal; SB and (imm[31:12] not all equal or imm[0]=1); U and imm[11:0]!=0; UJ and (imm[31:20] not all equal or imm[0]=1); fmt 5-7.
REQ-017 SHALL drive out_instr=32'h0 whenever out_err=1.
REQ-018 SHALL ignore unused fields per format (e.g. rs2 for I, rd for S/SB) without flagging error.
REQ-019 SHALL increment enc_count (wrapping at 16'hFFFF->0) on each out_valid&out_ready with out_err=0.
REQ-020 SHALL increment err_count on each out_valid&out_ready with out_err=1, saturating at 8'hFF.
REQ-021 SHALL NOT count while out_valid=1 and out_ready=0.

Reset
REQ-022 SHALL on rst_n=0 asynchronously clear S1.valid, S2.valid, out_valid=0, out_err=0, out_instr=0, enc_count=0, err_count=0.
REQ-023 SHALL drive in_ready=1 during and immediately after reset.
REQ-024 SHALL discard in-flight requests on reset mid-operation; no partial output after release.
REQ-025 SHALL accept its first request on the first rising edge with rst_n=1.

Verification
REQ-026 SHALL cover: fmt=I, opcode=0x13, funct3=0, rd=1, rs1=0, imm=5, out_ready=1 -> out_instr=0x00500093, out_err=0, two cycles after accept; enc_count=1.
REQ-027 SHALL cover back-to-back: SB opcode=0x63, rs1=1, rs2=2, imm=8 -> 0x00208463; then S opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; consecutive cycles.
REQ-028 SHALL cover UJ opcode=0x6F, rd=1, imm=0xFFFFFFFC -> 0xFFDFF0EF; U opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-029 SHALL cover errors: I imm=0x00000800, SB imm=3, U imm=0x00000001, fmt=6 -> each out_err=1, out_instr=0; err_count=4, enc_count unchanged.
REQ-030 SHALL cover backpressure: out_ready=0 for 5 cycles with 3 requests offered -> exactly 2 accepted, in_ready=0, outputs stable; release -> both delivered in order, third then accepted.
REQ-031 SHALL cover reset asserted with both stages full -> out_valid=0, counters=0 immediately (before next edge); 256 error handshakes -> err_count holds 0xFF.
